// File: rtl/sprite_line_scheduler_pkg.sv
// Shared constants, spriteViewRam field offsets and scheduler FSM encoding
// for the per-scanline sprite evaluator.
package sprite_line_scheduler_pkg;

    localparam int SPRITE_NUM_MAX  = 64;
    localparam int TILE_H          = 8;
    localparam int GAME_START_POSY = 0;
    localparam int GAME_H          = 240;

    localparam int POSY_MSB = 23;
    localparam int POSY_LSB = 16;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN,
        DONE
    } schedState_t;

endpackage

// File: rtl/sprite_slot_list.sv
// Shadow plus active sprite slot register file: hits fill the shadow side in
// arrival order, and a commit copies it to the active side seen by tileDraw.
module sprite_slot_list #(
    parameter int SLOTS   = 8,
    parameter int IDX_BIT = 6,
    parameter int CNT_BIT = $clog2(SLOTS + 1)
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic [IDX_BIT-1:0]       pushIndex,
    input  logic                     clear,
    input  logic                     commit,
    output logic [SLOTS*IDX_BIT-1:0] activeIndex,
    output logic [SLOTS-1:0]         activeValid,
    output logic [CNT_BIT-1:0]       count,
    output logic                     overflow
);

    logic [SLOTS-1:0][IDX_BIT-1:0] shadowIndex, shadowIndexNext;
    logic [SLOTS-1:0]              shadowValid, shadowValidNext;
    logic                          shadowOvf, shadowOvfNext;
    logic [CNT_BIT-1:0]            hitCnt, hitCntNext;

    assign count = hitCnt;

    // NOTE: every variable written here gets its default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        shadowIndexNext = shadowIndex;
        shadowValidNext = shadowValid;
        shadowOvfNext   = shadowOvf;
        hitCntNext      = hitCnt;
        if (push) begin
            if (hitCnt == CNT_BIT'(SLOTS)) begin
                shadowOvfNext = 1'b1;
            end else begin
                for (int k = 0; k < SLOTS; k++) begin
                    if (hitCnt == CNT_BIT'(k)) begin
                        shadowIndexNext[k] = pushIndex;
                        shadowValidNext[k] = 1'b1;
                    end
                end
                hitCntNext = hitCnt + CNT_BIT'(1);
            end
        end
    end

    // NOTE: the list is only SLOTS small entries, so it is reset like ordinary state rather than treated as an unreset RAM.
    // NOTE: sequential state uses <= so every flop updates from pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            shadowIndex <= '0;
            shadowValid <= '0;
            shadowOvf   <= 1'b0;
            hitCnt      <= '0;
            activeIndex <= '0;
            activeValid <= '0;
            overflow    <= 1'b0;
        end else begin
            // Commit takes the post-push view so a hit evaluated in the commit cycle is kept.
            if (commit) begin
                activeIndex <= shadowIndexNext;
                activeValid <= shadowValidNext;
                overflow    <= shadowOvfNext;
            end
            if (clear) begin
                shadowIndex <= '0;
                shadowValid <= '0;
                shadowOvf   <= 1'b0;
                hitCnt      <= '0;
            end else begin
                shadowIndex <= shadowIndexNext;
                shadowValid <= shadowValidNext;
                shadowOvf   <= shadowOvfNext;
                hitCnt      <= hitCntNext;
            end
        end
    end

endmodule

// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite evaluator: sweeps spriteViewRam during line N, keeps the
// first SLOTS sprites covering line N+1 and hands them to tileDraw at lineStart.
module sprite_line_scheduler
    import sprite_line_scheduler_pkg::*;
#(
    parameter int SPRITE_NUM = SPRITE_NUM_MAX,
    parameter int SLOTS      = 8,
    parameter int IDX_BIT    = $clog2(SPRITE_NUM),
    parameter int POSY_BIT   = 10
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     lineStart,
    input  logic                     frameStart,
    input  logic [POSY_BIT-1:0]      vgaPosY,
    output logic [IDX_BIT-1:0]       ramIndex,
    input  logic [31:0]              ramData,
    output logic [SLOTS*IDX_BIT-1:0] slotIndex,
    output logic [SLOTS-1:0]         slotValid,
    output logic                     lineOverflow,
    output logic                     frameOverflow,
    output logic                     scanLate,
    output logic                     busy
);

    localparam int                 CNT_BIT    = $clog2(SLOTS + 1);
    localparam logic [IDX_BIT-1:0] LAST_INDEX = IDX_BIT'(SPRITE_NUM - 1);
    localparam logic [POSY_BIT:0]  START_Y    = (POSY_BIT + 1)'(GAME_START_POSY);
    localparam logic [POSY_BIT:0]  GAME_END_Y = (POSY_BIT + 1)'(GAME_H);
    localparam logic [POSY_BIT:0]  SPRITE_H   = (POSY_BIT + 1)'(TILE_H);

    schedState_t        state, stateNext;
    logic [IDX_BIT-1:0] ramIndexNext;
    logic               tagValid;
    logic [IDX_BIT-1:0] tagIndex;
    logic [POSY_BIT:0]  targetY;
    logic [POSY_BIT:0]  spriteTop, spriteEnd;
    logic               hit, slotFull;
    logic [CNT_BIT-1:0] hitCnt;
    logic               unusedRamBits;

    assign unusedRamBits = ^{ramData[31:POSY_MSB+1], ramData[POSY_LSB-1:0]};

    // Wide enough that posY=252 covers 252..259 without wrapping.
    assign spriteTop = (POSY_BIT + 1)'(ramData[POSY_MSB:POSY_LSB]);
    assign spriteEnd = spriteTop + SPRITE_H;

    assign hit = tagValid && !targetY[POSY_BIT] && (targetY < GAME_END_Y)
              && (spriteTop <= targetY) && (targetY < spriteEnd);
    assign slotFull = (hitCnt == CNT_BIT'(SLOTS));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= IDLE;
            ramIndex <= '0;
        end else begin
            state    <= stateNext;
            ramIndex <= ramIndexNext;
        end
    end

    always_comb begin
        stateNext    = state;
        ramIndexNext = ramIndex;
        busy         = (state == SCAN) || (state == DRAIN);
        if (lineStart) begin
            stateNext    = SCAN;
            ramIndexNext = '0;
        end else begin
            case (state)
                SCAN: begin
                    if (ramIndex == LAST_INDEX) stateNext = DRAIN;
                    else                        ramIndexNext = ramIndex + IDX_BIT'(1);
                end
                DRAIN:   stateNext = DONE;
                default: stateNext = state;
            endcase
        end
    end

    // Read data lags the address by one cycle; a lineStart drops any datum still in flight.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            tagValid      <= 1'b0;
            tagIndex      <= '0;
            targetY       <= '0;
            frameOverflow <= 1'b0;
            scanLate      <= 1'b0;
        end else begin
            tagValid <= (state == SCAN) && !lineStart;
            tagIndex <= ramIndex;
            if (lineStart) begin
                targetY <= {1'b0, vgaPosY} + (POSY_BIT + 1)'(1) - START_Y;
            end
            frameOverflow <= (frameOverflow && !frameStart) || (hit && slotFull);
            scanLate      <= (scanLate && !frameStart) || (lineStart && busy);
        end
    end

    sprite_slot_list #(
        .SLOTS   (SLOTS),
        .IDX_BIT (IDX_BIT),
        .CNT_BIT (CNT_BIT)
    ) slotList (
        .clk         (clk),
        .rstn        (rstn),
        .push        (hit),
        .pushIndex   (tagIndex),
        .clear       (lineStart),
        .commit      (lineStart),
        .activeIndex (slotIndex),
        .activeValid (slotValid),
        .count       (hitCnt),
        .overflow    (lineOverflow)
    );

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Scoreboard bench for sprite_line_scheduler: each lineStart pushes the expected
// committed list from a list-level model; a monitor compares on the commit cycle.
module tb_sprite_line_scheduler;

    localparam int SPRITE_NUM = 64;
    localparam int SLOTS      = 8;
    localparam int IDX_BIT    = 6;
    localparam int POSY_BIT   = 10;
    localparam int GAME_H     = 240;
    localparam int TILE_H     = 8;
    localparam int FULL_GAP   = 70;

    typedef struct {
        logic [SLOTS*IDX_BIT-1:0] index;
        logic [SLOTS-1:0]         valid;
        logic                     lineOvf;
        logic                     frameOvf;
        logic                     late;
    } expLine_t;

    logic                     clk = 1'b0;
    logic                     rstn = 1'b0;
    logic                     lineStart = 1'b0;
    logic                     frameStart = 1'b0;
    logic [POSY_BIT-1:0]      vgaPosY = '0;
    logic [IDX_BIT-1:0]       ramIndex;
    logic [31:0]              ramData;
    logic [SLOTS*IDX_BIT-1:0] slotIndex;
    logic [SLOTS-1:0]         slotValid;
    logic                     lineOverflow, frameOverflow, scanLate, busy;

    logic [31:0] mem  [SPRITE_NUM];
    logic [31:0] snap [SPRITE_NUM];
    expLine_t    expQ [$];

    int passCnt = 0;
    int checkCnt = 0;
    int cyc = 0;
    int since = 1000;
    int prevStart = 0;
    int prevTy = 0;
    bit hasPrev = 1'b0;
    bit stickyFrame = 1'b0;
    bit stickyLate = 1'b0;

    sprite_line_scheduler dut (
        .clk           (clk),
        .rstn          (rstn),
        .lineStart     (lineStart),
        .frameStart    (frameStart),
        .vgaPosY       (vgaPosY),
        .ramIndex      (ramIndex),
        .ramData       (ramData),
        .slotIndex     (slotIndex),
        .slotValid     (slotValid),
        .lineOverflow  (lineOverflow),
        .frameOverflow (frameOverflow),
        .scanLate      (scanLate),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ramData <= mem[ramIndex];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rstn)          since <= 1000;
        else if (lineStart) since <= 1;
        else if (since < 1000) since <= since + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checkCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    endtask

    // Reference: the first SLOTS covering sprites among the entries evaluated, in index order.
    function automatic expLine_t evalLine(input int ty, input int nEval);
        expLine_t r;
        int hits;
        int py;
        hits      = 0;
        r.index   = '0;
        r.valid   = '0;
        r.lineOvf = 1'b0;
        r.frameOvf = 1'b0;
        r.late    = 1'b0;
        for (int i = 0; i < nEval; i++) begin
            py = int'(snap[i][23:16]);
            if (ty >= 0 && ty < GAME_H && py <= ty && ty < py + TILE_H) begin
                if (hits < SLOTS) begin
                    r.index[hits*IDX_BIT +: IDX_BIT] = IDX_BIT'(i);
                    r.valid[hits] = 1'b1;
                end else begin
                    r.lineOvf = 1'b1;
                end
                hits++;
            end
        end
        return r;
    endfunction

    always @(negedge clk) begin
        expLine_t e;
        if (rstn && since <= SPRITE_NUM) check("ramIndex_sweep", ramIndex, since - 1);
        if (rstn && since <= SPRITE_NUM + 1) check("busy_during_scan", busy, 1);
        if (rstn && since == SPRITE_NUM + 2) check("busy_end_66", busy, 0);
        if (rstn && since == 1) begin
            if (expQ.size() == 0) begin
                checkCnt++;
                $display("FAIL commit_unexpected: commit seen with no expectation at cycle %0d", cyc);
            end else begin
                e = expQ.pop_front();
                check("slotIndex", slotIndex, e.index);
                check("slotValid", slotValid, e.valid);
                check("lineOverflow", lineOverflow, e.lineOvf);
                check("frameOverflow", frameOverflow, e.frameOvf);
                check("scanLate", scanLate, e.late);
            end
        end
    end

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic issueLine(input int posY, input bit fs);
        expLine_t e;
        int startCyc, delta, nEval;
        bit late;
        @(posedge clk); #1;
        startCyc = cyc + 1;
        late = 1'b0;
        if (hasPrev) begin
            delta = startCyc - prevStart;
            nEval = (delta - 1 > SPRITE_NUM) ? SPRITE_NUM : delta - 1;
            e = evalLine(prevTy, nEval);
            late = (delta <= SPRITE_NUM + 1);
        end else begin
            e = evalLine(0, 0);
        end
        stickyFrame = stickyFrame | e.lineOvf;
        stickyLate  = stickyLate | late;
        if (fs) begin
            stickyFrame = 1'b0;
            stickyLate  = 1'b0;
        end
        e.frameOvf = stickyFrame;
        e.late     = stickyLate;
        expQ.push_back(e);
        for (int i = 0; i < SPRITE_NUM; i++) snap[i] = mem[i];
        prevTy    = posY + 1;
        prevStart = startCyc;
        hasPrev   = 1'b1;
        lineStart  = 1'b1;
        frameStart = fs;
        vgaPosY    = POSY_BIT'(posY);
        @(posedge clk); #1;
        lineStart  = 1'b0;
        frameStart = 1'b0;
    endtask

    task automatic applyReset();
        @(posedge clk); #1;
        rstn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_slotValid", slotValid, 0);
        check("rst_slotIndex", slotIndex, 0);
        check("rst_busy", busy, 0);
        check("rst_ramIndex", ramIndex, 0);
        check("rst_flags", {lineOverflow, frameOverflow, scanLate}, 0);
        hasPrev     = 1'b0;
        stickyFrame = 1'b0;
        stickyLate  = 1'b0;
        rstn = 1'b1;
    endtask

    task automatic fillBackground();
        for (int i = 0; i < SPRITE_NUM; i++) begin
            mem[i] = $urandom();
            mem[i][23:16] = 8'hFF;
        end
    endtask

    initial begin
        int base, lo, hi;
        bit late, fs;
        fillBackground();
        applyReset();

        // Single hit: sprite 5 at posY 100, line ty=101.
        mem[5][23:16] = 8'd100;
        issueLine(100, 1'b1);
        gap(FULL_GAP);

        // Coverage boundaries of sprite 3 at posY 100: ty 99, 100, 107, 108.
        fillBackground();
        mem[3][23:16] = 8'd100;
        issueLine(98, 1'b0);  gap(FULL_GAP);
        issueLine(99, 1'b0);  gap(FULL_GAP);
        issueLine(106, 1'b0); gap(FULL_GAP);
        issueLine(107, 1'b0); gap(FULL_GAP);

        // posY 252 at ty 259 lies outside the game area.
        fillBackground();
        mem[4][23:16] = 8'd252;
        issueLine(258, 1'b0); gap(FULL_GAP);
        fillBackground();
        mem[9][23:16] = 8'd232;
        issueLine(238, 1'b0); gap(FULL_GAP);

        // Ten sprites on one line: eight kept, overflow flagged, frameStart clears the sticky flag.
        fillBackground();
        for (int i = 0; i < 10; i++) mem[i][23:16] = 8'd50;
        issueLine(51, 1'b0);  gap(FULL_GAP);
        fillBackground();
        issueLine(600, 1'b0); gap(FULL_GAP);
        issueLine(600, 1'b1); gap(FULL_GAP);

        // Late lineStart 20 cycles in: indices 0..18 committed, scan restarts.
        fillBackground();
        mem[2][23:16]  = 8'd60;
        mem[10][23:16] = 8'd60;
        mem[18][23:16] = 8'd60;
        mem[19][23:16] = 8'd60;
        mem[30][23:16] = 8'd60;
        issueLine(61, 1'b0);
        gap(18);
        issueLine(61, 1'b0);  gap(FULL_GAP);
        issueLine(700, 1'b0); gap(FULL_GAP);
        issueLine(700, 1'b1); gap(FULL_GAP);

        // Reset in the middle of a scan.
        issueLine(61, 1'b0);
        gap(10);
        applyReset();
        issueLine(61, 1'b0);  gap(FULL_GAP);

        for (int n = 0; n < 40; n++) begin
            base = int'($urandom_range(0, 250));
            late = ($urandom_range(0, 3) == 0);
            if (late) begin
                gap(int'($urandom_range(0, 63)));
            end else begin
                gap(FULL_GAP);
                lo = (base > 12) ? base - 12 : 0;
                hi = (base + 4 > 255) ? 255 : base + 4;
                for (int i = 0; i < SPRITE_NUM; i++) begin
                    mem[i] = $urandom();
                    mem[i][23:16] = 8'($urandom_range(lo, hi));
                end
            end
            fs = !late && ($urandom_range(0, 4) == 0);
            issueLine(base + int'($urandom_range(0, 3)), fs);
        end
        gap(FULL_GAP);
        issueLine(0, 1'b0);
        gap(4);

        check("queue_drained", expQ.size(), 0);
        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule

// File: doc/sprite_line_scheduler.md
Name: sprite_line_scheduler

Overview:
- Per-scanline sprite evaluator and slot allocator for the PPU sprite path.
- During display line N, it scans every spriteViewRam entry and keeps up to SLOTS sprites whose Y range covers line N+1. At the start of line N+1 it hands those indices to the SLOTS parallel tileDraw instances through their inSpriteViewRamIndex inputs.
- It owns the spriteViewRam read port used for evaluation and flags per-line overflow.

Parameters:
- SPRITE_NUM, 64, entries in spriteViewRam (power of two).
- SLOTS, 8, tileDraw instances fed per line.
- IDX_BIT, $clog2(SPRITE_NUM), sprite index width.
- POSY_BIT, 10, VGA Y coordinate width.
- TILE_H, 8, sprite height in lines.
- GAME_START_POSY, 0, VGA line of game row 0.
- GAME_H, 240, game-area height in lines.

Ports:
- clk  in  1  system clock; faster than the VGA pixel clock.
- rstn  in  1  synchronous active-low reset.
- lineStart  in  1  one-cycle pulse at the start of each VGA line.
- frameStart  in  1  one-cycle pulse at the start of each frame (line 0).
- vgaPosY  in  POSY_BIT  current VGA line, valid when lineStart is high.
- ramIndex  out  IDX_BIT  spriteViewRam read address.
- ramData  in  32  {posX, posY, tileIdx, attr}; synchronous read, 1-cycle latency.
- slotIndex  out  SLOTS*IDX_BIT  active sprite index per slot; slot k at [k*IDX_BIT +: IDX_BIT].
- slotValid  out  SLOTS  active slot enables, used to gate IsScanRange per tileDraw.
- lineOverflow  out  1  more than SLOTS hits found for the current active line.
- frameOverflow  out  1  sticky; cleared by frameStart.
- scanLate  out  1  sticky; a lineStart arrived before the scan finished; cleared by frameStart.
- busy  out  1  high while in SCAN or DRAIN.

Behaviour:
- Reset (rstn=0 at a clk edge):
  - state=IDLE; ramIndex=0.
  - All shadow and active lists cleared: slotIndex=0, slotValid=0.
  - All flags=0; busy=0.
- States: IDLE, SCAN, DRAIN, DONE.
- On lineStart, in any state:
  - Commit: active list <= shadow list, slotValid <= shadowValid, lineOverflow <= shadowOvf. Takes effect the cycle after lineStart.
  - Clear the shadow list, hit counter and shadowOvf.
  - Compute target ty = vgaPosY + 1 - GAME_START_POSY in POSY_BIT+1 bits, with the sign bit kept.
  - Enter SCAN with ramIndex=0.
  - If lineStart arrives in SCAN or DRAIN: the partial shadow is committed as above, scanLate is set, and the scan restarts.
- SCAN:
  - ramIndex increments by 1 each cycle.
  - Data returns one cycle later, tagged with a delayed copy of the index.
  - After issuing SPRITE_NUM-1, go to DRAIN for one cycle so the last datum can be evaluated.
- DRAIN -> DONE.
- DONE: hold until the next lineStart. busy=0 in IDLE and DONE.
- Hit test, for each returned entry:
  - py = ramData[23:16], zero-extended.
  - Hit iff ty is non-negative, ty < GAME_H, py <= ty, and ty < py + TILE_H.
  - The sum py + TILE_H is computed in 9 bits (no wrap), so py=252 covers lines 252..259.
- Slot allocation:
  - Hits are stored in ascending index order into shadow slot hitCnt, and hitCnt is incremented.
  - A hit found when hitCnt==SLOTS sets shadowOvf and frameOverflow; the hit is discarded.
  - Lower index wins, i.e. it has higher drawing priority.
- Scan length is SPRITE_NUM+2 cycles after lineStart. This must fit in one VGA line; the current clock ratio gives more than 800 clk cycles per line.
- frameStart and lineStart in the same cycle: the flags are cleared first, then the line processing proceeds normally.
- Active outputs are stable for the whole line. They change only on the cycle after lineStart.

Decomposition:
- Shared package / define.v:
  - SPRITE_NUM_MAX, TILE_H, GAME_START_POSY, GAME_H, the spriteViewRam field offsets (POSY_MSB/LSB), and the state encodings for the scheduler FSM.
- One sub-module: sprite_slot_list.
  - Shadow plus active register file of SLOTS entries.
  - Inputs: push, clear, commit.
  - Outputs: count and overflow.
- The FSM, address counter and hit comparator stay in the top.

Test Plan:
- Single hit: sprite 5 posY=100, all others posY=255; lineStart with vgaPosY=100 (ty=101), then a second lineStart -> slotIndex[0]=5, slotValid=8'h01, lineOverflow=0.
- Boundaries: sprite 3 posY=100; check ty=99 miss, ty=100 hit, ty=107 hit, ty=108 miss. Sprite 4 posY=252 with ty=259: hit only if GAME_H>259, otherwise rejected by the GAME_H rule.
- Overflow: sprites 0..9 posY=50; evaluate ty=52 -> slots hold 0..7, slotValid=8'hFF, lineOverflow=1, frameOverflow=1; the next frameStart clears frameOverflow.
- Late line: lineStart again 20 cycles after the first -> scanLate=1, the partial list from indices 0..18 is committed, and a fresh scan starts at ramIndex=0.
- Reset mid-scan: rstn=0 while in SCAN -> next cycle state=IDLE, slotValid=0, busy=0, ramIndex=0, all flags 0.
- Timing: after lineStart, busy deasserts exactly SPRITE_NUM+2 cycles later (66 with the default); ramIndex sweeps 0..63 once with no gaps.
